mystic_mem_arbiter: RTL and testbench
=====================================

MYSTIC_MEM_ARBITER -- requirements
Module: mystic_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024, read-response watchdog limit in cycles; used only with the macro.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 if_req_i  in  1  fetch request; level, held until if_ack_o.
REQ-005 if_addr_i  in  32  fetch address.
REQ-006 if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-007 if_instr_o / if_is_compressed_o  out  32 / 1  fetched instruction and compressed flag; valid with if_ack_o, held until the next fetch ack.
REQ-008 lsu_req_i, lsu_we_i  in  1, 1  data request (level, held until lsu_ack_o) and write select.
REQ-009 lsu_addr_i, lsu_byte_len_i, lsu_wdata_i  in  32, 5, 64  data address, byte count, write data.
REQ-010 lsu_ack_o, lsu_err_o  out  1, 1  one-cycle completion pulse; error flag valid with ack.
REQ-011 lsu_rdata_o  out  64  load data; valid with lsu_ack_o, held until the next load ack.
REQ-012 mem_we_o, mem_rd_instr_o, mem_rd_data_o  out  1 each  one-cycle command strobes to main memory.
REQ-013 mem_addr_o, mem_byte_len_o, mem_din_o  out  32, 5, 64  command fields; stable from the strobe cycle until return to IDLE.
REQ-014 mem_dout_i, mem_instr_i, mem_is_compressed_i, mem_dout_ready_i  in  64, 32, 1, 1  memory response; mem_dout_ready_i is a one-cycle pulse.
REQ-015 busy_o  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: with any request pending, grant and latch that requester's fields into the command registers, then go to ISSUE.
REQ-018 Both requests pending in IDLE: grant the requester not granted last (round-robin); after reset, LSU wins the first tie.
REQ-019 ISSUE: assert exactly one strobe for one cycle. Fetch drives mem_rd_instr_o with byte_len 4. Load drives mem_rd_data_o. Store drives mem_we_o.
REQ-020 ISSUE to WAIT for reads. ISSUE to RESP for stores; memory gives no write response.
REQ-021 WAIT: on mem_dout_ready_i, register mem_dout_i, mem_instr_i and mem_is_compressed_i, then go to RESP.
REQ-022 RESP: pulse the granted requester's ack for one cycle, then go to IDLE. The other requester is not re-examined until IDLE.
REQ-023 Latency: store ack 2 cycles after the grant edge. Read ack 1 cycle after the mem_dout_ready_i cycle.
REQ-024 mem_dout_ready_i is ignored outside WAIT.
REQ-025 lsu_byte_len_i outside {1,2,4,8}: no memory strobe; go directly to RESP; lsu_err_o=1 with ack.
REQ-026 lsu_err_o is 0 for every other ack.
REQ-027 Requests that drop before ack are protocol violations. Behaviour is undefined, but the FSM always returns to IDLE.

Reset
REQ-028 rstn_i low: state=IDLE; all strobes, acks, lsu_err_o and busy_o =0; rdata/instr/addr/len/din registers =0; round-robin pointer =LSU-next.
REQ-029 Reset mid-transaction abandons it with no ack; a late mem_dout_ready_i is ignored under REQ-024.

Configuration
REQ-030 Macro MYSTIC_ARB_TIMEOUT_EN defined: a WAIT counter cleared on WAIT entry. At TIMEOUT_CYC cycles without mem_dout_ready_i: go to RESP and ack. Load abort: lsu_err_o=1, lsu_rdata_o=0. Fetch abort: if_instr_o=0.
REQ-031 Macro undefined: no counter; WAIT persists until mem_dout_ready_i.

Structure
REQ-032 Package mystic_pkg: FSM state enum, grant enum {GNT_IF, GNT_LSU}, valid byte-length constants.
REQ-033 Sub-module mystic_rr_arb2 (2-way round-robin grant with pointer). Everything else is in one module.

Verification
REQ-034 Store: lsu_req, we=1, addr 0, len 8, wdata 64'h0123456789abcdef -> mem_we_o pulse with those fields; lsu_ack 2 cycles after grant.
REQ-035 Load: addr 2, len 4; memory returns 64'h89abcdef three cycles after strobe -> lsu_rdata_o=64'h89abcdef with ack one cycle later, err=0.
REQ-036 Simultaneous if_req and lsu_req after reset -> LSU served first, fetch next. Repeat the tie -> fetch served first.
REQ-037 Fetch at addr 0 returning instr 32'h00000513, compressed=0 -> if_ack with those values; mem_byte_len_o=4.
REQ-038 Load with len 3 -> no strobe; lsu_ack with lsu_err_o=1.
REQ-039 MYSTIC_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, memory silent -> ack with err=1 at cycle 16 of WAIT. Reset asserted mid-WAIT -> immediately IDLE, no ack.

Source files
------------

// File: rtl/mystic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mystic_pkg                                                   |
// | Description : Shared types and constants for the mystic memory arbiter:    |
// |               FSM state encoding, grant identifiers and the set of legal   |
// |               LSU byte lengths.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mystic_pkg;

  // Arbiter transaction FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Requester identity; also the encoding of the round-robin pointer.
  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_LSU = 1'b1
  } gnt_t;

  // Legal LSU transfer sizes in bytes.
  localparam logic [4:0] c_len_b1 = 5'd1;
  localparam logic [4:0] c_len_b2 = 5'd2;
  localparam logic [4:0] c_len_b4 = 5'd4;
  localparam logic [4:0] c_len_b8 = 5'd8;

  // Instruction fetches are always one 32-bit word.
  localparam logic [4:0] c_fetch_len = c_len_b4;

  function automatic logic len_is_valid(input logic [4:0] len);
    return (len == c_len_b1) || (len == c_len_b2) ||
           (len == c_len_b4) || (len == c_len_b8);
  endfunction

endpackage : mystic_pkg
`default_nettype wire

// File: rtl/mystic_mem_arbiter_rr.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mystic_rr_arb2                                               |
// | Description : Two-way round-robin arbiter between instruction fetch and    |
// |               the LSU. A pointer names the requester that wins the next    |
// |               tie; it flips to the other requester whenever a grant is     |
// |               accepted, so the requester not granted last wins a tie.      |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports                                                                      |
// |   clk_i        in   clock                                                  |
// |   rstn_i       in   asynchronous active-low reset (pointer -> LSU)         |
// |   req_if_i     in   fetch request pending                                  |
// |   req_lsu_i    in   data request pending                                   |
// |   accept_i     in   current grant taken by the FSM this cycle              |
// |   gnt_valid_o  out  at least one request pending                           |
// |   gnt_o        out  winning requester                                      |
// +----------------------------------------------------------------------------+
module mystic_rr_arb2
  import mystic_pkg::*;
(
  input  logic clk_i,
  input  logic rstn_i,
  input  logic req_if_i,
  input  logic req_lsu_i,
  input  logic accept_i,
  output logic gnt_valid_o,
  output gnt_t gnt_o
);

  gnt_t r_next;

  assign gnt_valid_o = req_if_i | req_lsu_i;

  always_comb begin
    gnt_o = r_next;
    if (req_if_i && !req_lsu_i) begin
      gnt_o = GNT_IF;
    end else if (req_lsu_i && !req_if_i) begin
      gnt_o = GNT_LSU;
    end
  end

  // The pointer follows every accepted grant, including uncontended ones,
  // so a tie always goes to whoever was served less recently.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_next <= GNT_LSU;
    end else if (accept_i && gnt_valid_o) begin
      r_next <= (gnt_o == GNT_LSU) ? GNT_IF : GNT_LSU;
    end
  end

endmodule : mystic_rr_arb2
`default_nettype wire

// File: rtl/mystic_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mystic_mem_arbiter                                           |
// | Description : Shares one main-memory command port between an instruction  |
// |               fetch unit and an LSU. One transaction at a time:            |
// |               IDLE (grant + latch) -> ISSUE (one strobe) -> WAIT (reads    |
// |               only) -> RESP (one-cycle ack) -> IDLE. Illegal LSU lengths   |
// |               skip memory and are acked with an error.                     |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Build option                                                               |
// |   MYSTIC_ARB_TIMEOUT_EN  when defined, a read that sees no                 |
// |                          mem_dout_ready_i for TIMEOUT_CYC WAIT cycles is   |
// |                          aborted: load acks with error and zero data,      |
// |                          fetch acks with a zero instruction.               |
// |                                                                            |
// | Ports                                                                      |
// |   clk_i, rstn_i                    clock, async active-low reset           |
// |   if_req_i, if_addr_i              fetch request (level) and address       |
// |   if_ack_o                         fetch completion pulse                  |
// |   if_instr_o, if_is_compressed_o   fetched word, held until next fetch ack |
// |   lsu_req_i, lsu_we_i              data request (level), write select      |
// |   lsu_addr_i, lsu_byte_len_i       data address, byte count                |
// |   lsu_wdata_i                      store data                              |
// |   lsu_ack_o, lsu_err_o             completion pulse, error with ack        |
// |   lsu_rdata_o                      load data, held until next load ack     |
// |   mem_we_o, mem_rd_instr_o,        one-cycle memory command strobes        |
// |   mem_rd_data_o                                                            |
// |   mem_addr_o, mem_byte_len_o,      command fields, stable until IDLE       |
// |   mem_din_o                                                                |
// |   mem_dout_i, mem_instr_i,         memory read response                    |
// |   mem_is_compressed_i,                                                     |
// |   mem_dout_ready_i                 response valid pulse                    |
// |   busy_o                           high whenever not IDLE                  |
// +----------------------------------------------------------------------------+
module mystic_mem_arbiter
  import mystic_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  // fetch port
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_instr_o,
  output logic        if_is_compressed_o,
  // LSU port
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [4:0]  lsu_byte_len_i,
  input  logic [63:0] lsu_wdata_i,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  output logic [63:0] lsu_rdata_o,
  // memory command
  output logic        mem_we_o,
  output logic        mem_rd_instr_o,
  output logic        mem_rd_data_o,
  output logic [31:0] mem_addr_o,
  output logic [4:0]  mem_byte_len_o,
  output logic [63:0] mem_din_o,
  // memory response
  input  logic [63:0] mem_dout_i,
  input  logic [31:0] mem_instr_i,
  input  logic        mem_is_compressed_i,
  input  logic        mem_dout_ready_i,
  // status
  output logic        busy_o
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  gnt_t        r_gnt;
  gnt_t        w_gnt;
  logic        w_gnt_valid;
  logic        w_accept;
  logic        w_lsu_len_ok;
  logic        w_timeout;

  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [4:0]  r_len;
  logic [63:0] r_din;
  logic [63:0] r_rdata;
  logic [31:0] r_instr;
  logic        r_cmp;

  assign w_lsu_len_ok = len_is_valid(lsu_byte_len_i);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  mystic_rr_arb2 u_rr_arb (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_if_i    (if_req_i),
    .req_lsu_i   (lsu_req_i),
    .accept_i    (w_accept),
    .gnt_valid_o (w_gnt_valid),
    .gnt_o       (w_gnt)
  );

  // --------------------------------------------------------------------------
  // Read watchdog
  // --------------------------------------------------------------------------
`ifdef MYSTIC_ARB_TIMEOUT_EN
  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_wait_cnt;

  // Held at zero outside WAIT, so it is zero on the first WAIT cycle and
  // reaches TIMEOUT_CYC-1 on the TIMEOUT_CYC-th one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wait_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + c_cnt_one;
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && !mem_dout_ready_i &&
                     (r_wait_cnt == c_cnt_last);
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_accept = 1'b1;
          // An illegal LSU length never reaches memory.
          if ((w_gnt == GNT_LSU) && !w_lsu_len_ok) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // Memory sends no write response, so stores complete immediately.
        if ((r_gnt == GNT_LSU) && r_we) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_dout_ready_i || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Command and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_gnt   <= GNT_IF;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_din   <= '0;
      r_rdata <= '0;
      r_instr <= '0;
      r_cmp   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_gnt <= w_gnt;
            if (w_gnt == GNT_LSU) begin
              r_we   <= lsu_we_i;
              r_addr <= lsu_addr_i;
              r_len  <= lsu_byte_len_i;
              r_din  <= lsu_wdata_i;
              r_err  <= !w_lsu_len_ok;
            end else begin
              r_we   <= 1'b0;
              r_addr <= if_addr_i;
              r_len  <= c_fetch_len;
              r_din  <= '0;
              r_err  <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          // Response data goes straight into the held output registers so it
          // is visible during RESP and survives until the next matching ack.
          if (mem_dout_ready_i) begin
            if (r_gnt == GNT_LSU) begin
              r_rdata <= mem_dout_i;
            end else begin
              r_instr <= mem_instr_i;
              r_cmp   <= mem_is_compressed_i;
            end
          end else if (w_timeout) begin
            if (r_gnt == GNT_LSU) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end else begin
              r_instr <= '0;
              r_cmp   <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // --------------------------------------------------------------------------
  assign mem_we_o       = (r_state == ST_ISSUE) && (r_gnt == GNT_LSU) &&  r_we;
  assign mem_rd_data_o  = (r_state == ST_ISSUE) && (r_gnt == GNT_LSU) && !r_we;
  assign mem_rd_instr_o = (r_state == ST_ISSUE) && (r_gnt == GNT_IF);
  assign mem_addr_o     = r_addr;
  assign mem_byte_len_o = r_len;
  assign mem_din_o      = r_din;

  assign if_ack_o           = (r_state == ST_RESP) && (r_gnt == GNT_IF);
  assign if_instr_o         = r_instr;
  assign if_is_compressed_o = r_cmp;

  assign lsu_ack_o   = (r_state == ST_RESP) && (r_gnt == GNT_LSU);
  assign lsu_err_o   = lsu_ack_o && r_err;
  assign lsu_rdata_o = r_rdata;

  assign busy_o = (r_state != ST_IDLE);

endmodule : mystic_mem_arbiter
`default_nettype wire

// File: tb/tb_mystic_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mystic_mem_arbiter                                        |
// | Description : Directed self-checking bench for mystic_mem_arbiter with a   |
// |               scoreboard of expected acks (pushed on request, popped on    |
// |               ack). Memory responses are driven from the same sequence.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mystic_mem_arbiter;

  localparam int TIMEOUT_CYC = 16;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_instr_o;
  logic        if_is_compressed_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [4:0]  lsu_byte_len_i;
  logic [63:0] lsu_wdata_i;
  logic        lsu_ack_o;
  logic        lsu_err_o;
  logic [63:0] lsu_rdata_o;
  logic        mem_we_o;
  logic        mem_rd_instr_o;
  logic        mem_rd_data_o;
  logic [31:0] mem_addr_o;
  logic [4:0]  mem_byte_len_o;
  logic [63:0] mem_din_o;
  logic [63:0] mem_dout_i;
  logic [31:0] mem_instr_i;
  logic        mem_is_compressed_i;
  logic        mem_dout_ready_i;
  logic        busy_o;

  mystic_mem_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .if_req_i            (if_req_i),
    .if_addr_i           (if_addr_i),
    .if_ack_o            (if_ack_o),
    .if_instr_o          (if_instr_o),
    .if_is_compressed_o  (if_is_compressed_o),
    .lsu_req_i           (lsu_req_i),
    .lsu_we_i            (lsu_we_i),
    .lsu_addr_i          (lsu_addr_i),
    .lsu_byte_len_i      (lsu_byte_len_i),
    .lsu_wdata_i         (lsu_wdata_i),
    .lsu_ack_o           (lsu_ack_o),
    .lsu_err_o           (lsu_err_o),
    .lsu_rdata_o         (lsu_rdata_o),
    .mem_we_o            (mem_we_o),
    .mem_rd_instr_o      (mem_rd_instr_o),
    .mem_rd_data_o       (mem_rd_data_o),
    .mem_addr_o          (mem_addr_o),
    .mem_byte_len_o      (mem_byte_len_o),
    .mem_din_o           (mem_din_o),
    .mem_dout_i          (mem_dout_i),
    .mem_instr_i         (mem_instr_i),
    .mem_is_compressed_i (mem_is_compressed_i),
    .mem_dout_ready_i    (mem_dout_ready_i),
    .busy_o              (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_tests  = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int strb_cnt = 0;
  int last_ack_cyc    = 0;
  int last_strobe_cyc = 0;

  typedef struct {
    logic        is_lsu;
    logic        chk_data;
    logic [63:0] data;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (if_ack_o || lsu_ack_o) ack_cnt <= ack_cnt + 1;
    if (mem_we_o || mem_rd_instr_o || mem_rd_data_o) strb_cnt <= strb_cnt + 1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_lsu, input logic chk_data,
                          input logic [63:0] data, input logic err, input string tag);
    exp_t e;
    e.is_lsu   = is_lsu;
    e.chk_data = chk_data;
    e.data     = data;
    e.err      = err;
    e.tag      = tag;
    sb.push_back(e);
    n_pushed++;
  endtask

  task automatic sb_check();
    exp_t e;
    last_ack_cyc = cyc;
    if (sb.size() == 0) begin
      chk("sb_unexpected_ack", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_ack_kind"}, 64'({if_ack_o, lsu_ack_o}), e.is_lsu ? 64'd1 : 64'd2);
      if (e.is_lsu) begin
        chk({e.tag, "_err"}, 64'(lsu_err_o), 64'(e.err));
        if (e.chk_data) chk({e.tag, "_rdata"}, lsu_rdata_o, e.data);
      end else begin
        chk({e.tag, "_instr"}, 64'({if_is_compressed_o, if_instr_o}), e.data);
      end
    end
  endtask

  task automatic lsu_drive(input logic we, input logic [31:0] addr,
                           input logic [4:0] len, input logic [63:0] wdata);
    lsu_we_i       = we;
    lsu_addr_i     = addr;
    lsu_byte_len_i = len;
    lsu_wdata_i    = wdata;
    lsu_req_i      = 1'b1;
  endtask

  // Any one-cycle memory response pulse is retired (and its data poisoned)
  // on the negedge where the ack is expected.
  task automatic wait_ack(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i);
      if (mem_dout_ready_i) begin
        mem_dout_ready_i    = 1'b0;
        mem_dout_i          = 64'hdead_beef_dead_beef;
        mem_instr_i         = 32'hdead_beef;
        mem_is_compressed_i = 1'b1;
      end
      if (if_ack_o || lsu_ack_o) begin
        seen = 1'b1;
        sb_check();
      end
    end
    if (!seen) chk({tag, "_ack_timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic wait_strobe(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      if (mem_we_o || mem_rd_instr_o || mem_rd_data_o) begin
        seen = 1'b1;
        last_strobe_cyc = cyc;
      end
    end
    if (!seen) chk({tag, "_strobe_timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic mem_respond(input int delay, input logic [63:0] dout,
                             input logic [31:0] instr, input logic cmp);
    repeat (delay) @(negedge clk_i);
    mem_dout_i          = dout;
    mem_instr_i         = instr;
    mem_is_compressed_i = cmp;
    mem_dout_ready_i    = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin : stim
    int req_cyc;
    int s0;

    rstn_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0;
    lsu_byte_len_i = '0; lsu_wdata_i = '0;
    mem_dout_i = '0; mem_instr_i = '0; mem_is_compressed_i = 1'b0;
    mem_dout_ready_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_busy",    64'(busy_o), 64'd0);
    chk("rst_acks",    64'({if_ack_o, lsu_ack_o, lsu_err_o}), 64'd0);
    chk("rst_strobes", 64'({mem_we_o, mem_rd_instr_o, mem_rd_data_o}), 64'd0);
    chk("rst_rdata",   lsu_rdata_o, 64'd0);
    chk("rst_instr",   64'({if_is_compressed_o, if_instr_o}), 64'd0);
    chk("rst_cmd",     64'({mem_addr_o, mem_byte_len_o}), 64'd0);
    chk("rst_din",     mem_din_o, 64'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Store: ack two cycles after the request is first seen
    push_exp(1'b1, 1'b0, 64'd0, 1'b0, "store");
    lsu_drive(1'b1, 32'd0, 5'd8, 64'h0123_4567_89ab_cdef);
    req_cyc = cyc;
    @(negedge clk_i);
    chk("store_strobe",   64'({mem_we_o, mem_rd_instr_o, mem_rd_data_o}), 64'd4);
    chk("store_addr_len", 64'({mem_addr_o, mem_byte_len_o}), 64'd8);
    chk("store_din",      mem_din_o, 64'h0123_4567_89ab_cdef);
    chk("store_busy",     64'(busy_o), 64'd1);
    wait_ack("store");
    chk("store_latency", 64'(last_ack_cyc - req_cyc), 64'd2);
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    chk("store_idle", 64'(busy_o), 64'd0);

    // Load: memory answers three cycles after the strobe
    push_exp(1'b1, 1'b1, 64'h89ab_cdef, 1'b0, "load");
    lsu_drive(1'b0, 32'd2, 5'd4, 64'hffff_ffff_ffff_ffff);
    wait_strobe("load");
    chk("load_strobe",   64'({mem_we_o, mem_rd_instr_o, mem_rd_data_o}), 64'd1);
    chk("load_addr_len", 64'({mem_addr_o, mem_byte_len_o}), 64'({32'd2, 5'd4}));
    mem_respond(3, 64'h89ab_cdef, 32'h0, 1'b0);
    wait_ack("load");
    chk("load_latency", 64'(last_ack_cyc - last_strobe_cyc), 64'd4);
    lsu_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("load_rdata_held", lsu_rdata_o, 64'h89ab_cdef);

    // Response pulse while IDLE is ignored
    mem_dout_i = 64'hffff_ffff_ffff_ffff;
    mem_dout_ready_i = 1'b1;
    @(negedge clk_i);
    mem_dout_ready_i = 1'b0;
    @(negedge clk_i);
    chk("spurious_busy",  64'(busy_o), 64'd0);
    chk("spurious_rdata", lsu_rdata_o, 64'h89ab_cdef);

    // Fetch
    push_exp(1'b0, 1'b1, 64'({1'b0, 32'h0000_0513}), 1'b0, "fetch");
    if_addr_i = 32'd0;
    if_req_i  = 1'b1;
    wait_strobe("fetch");
    chk("fetch_strobe",   64'({mem_we_o, mem_rd_instr_o, mem_rd_data_o}), 64'd2);
    chk("fetch_addr_len", 64'({mem_addr_o, mem_byte_len_o}), 64'd4);
    mem_respond(2, 64'h5555_5555_5555_5555, 32'h0000_0513, 1'b0);
    wait_ack("fetch");
    if_req_i = 1'b0;
    chk("fetch_rdata_untouched", lsu_rdata_o, 64'h89ab_cdef);

    // Illegal length: no strobe, error ack the cycle after the request
    @(negedge clk_i);
    s0 = strb_cnt;
    push_exp(1'b1, 1'b1, 64'h89ab_cdef, 1'b1, "badlen");
    lsu_drive(1'b0, 32'd4, 5'd3, 64'd0);
    req_cyc = cyc;
    wait_ack("badlen");
    chk("badlen_latency", 64'(last_ack_cyc - req_cyc), 64'd1);
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    chk("badlen_no_strobe", 64'(strb_cnt - s0), 64'd0);

    // Ties after reset: LSU, then fetch (LSU re-requests at once), then LSU
    rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    push_exp(1'b1, 1'b0, 64'd0, 1'b0, "tie1_lsu");
    push_exp(1'b0, 1'b1, 64'({1'b1, 32'h0000_4501}), 1'b0, "tie2_if");
    lsu_drive(1'b1, 32'h8, 5'd8, 64'h1111);
    if_addr_i = 32'h40;
    if_req_i  = 1'b1;
    wait_ack("tie1");
    lsu_drive(1'b1, 32'h10, 5'd2, 64'h22);
    push_exp(1'b1, 1'b0, 64'd0, 1'b0, "tie2_lsu");
    wait_strobe("tie2");
    chk("tie2_fetch_first", 64'({mem_we_o, mem_rd_instr_o, mem_rd_data_o}), 64'd2);
    chk("tie2_fetch_addr",  64'(mem_addr_o), 64'h40);
    mem_respond(1, 64'd0, 32'h0000_4501, 1'b1);
    wait_ack("tie2_if");
    if_req_i = 1'b0;
    wait_ack("tie2_lsu");
    lsu_req_i = 1'b0;

    // Reset while waiting for read data: abandoned, late response ignored
    @(negedge clk_i);
    lsu_drive(1'b0, 32'h20, 5'd8, 64'd0);
    wait_strobe("rstwait");
    @(negedge clk_i);
    chk("rstwait_busy", 64'(busy_o), 64'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("rstwait_async_idle", 64'({busy_o, lsu_ack_o}), 64'd0);
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    mem_dout_i = 64'h0bad_0bad_0bad_0bad;
    mem_dout_ready_i = 1'b1;
    @(negedge clk_i);
    mem_dout_ready_i = 1'b0;
    @(negedge clk_i);
    chk("rstwait_late_busy",  64'(busy_o), 64'd0);
    chk("rstwait_late_rdata", lsu_rdata_o, 64'd0);

`ifdef MYSTIC_ARB_TIMEOUT_EN
    // Silent memory: abort after TIMEOUT_CYC WAIT cycles
    push_exp(1'b1, 1'b1, 64'd0, 1'b1, "timeout");
    lsu_drive(1'b0, 32'h28, 5'd8, 64'd0);
    wait_strobe("timeout");
    wait_ack("timeout");
    chk("timeout_latency", 64'(last_ack_cyc - last_strobe_cyc), 64'(TIMEOUT_CYC + 1));
    lsu_req_i = 1'b0;
`else
    // Slow memory: WAIT persists until the response arrives
    push_exp(1'b1, 1'b1, 64'hfeed_face_cafe_f00d, 1'b0, "slow");
    lsu_drive(1'b0, 32'h28, 5'd8, 64'd0);
    wait_strobe("slow");
    s0 = ack_cnt;
    repeat (40) @(negedge clk_i);
    chk("slow_still_busy", 64'(busy_o), 64'd1);
    chk("slow_no_ack",     64'(ack_cnt - s0), 64'd0);
    mem_respond(1, 64'hfeed_face_cafe_f00d, 32'h0, 1'b0);
    wait_ack("slow");
    lsu_req_i = 1'b0;
`endif

    repeat (3) @(negedge clk_i);
    chk("ack_count", 64'(ack_cnt), 64'(n_pushed));
    chk("sb_empty",  64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mystic_mem_arbiter
`default_nettype wire
